// File: rtl/guess_pkg.sv
// Shared letter-entry types and constants: code width, default letter range,
// FSM state encoding and the wrapping step helpers.
package guess_pkg;

    localparam int LETTER_W       = 5;
    localparam int LETTER_MAX_DEF = 25;

    typedef enum logic {
        SELECT  = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Wrap by explicit compare so an out-of-range code can never persist.
    function automatic logic [LETTER_W-1:0] code_inc(input logic [LETTER_W-1:0] c,
                                                     input logic [LETTER_W-1:0] max_c);
        return (c >= max_c) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [LETTER_W-1:0] code_dec(input logic [LETTER_W-1:0] c,
                                                     input logic [LETTER_W-1:0] max_c);
        return ((c == '0) || (c > max_c)) ? max_c : c - 1'b1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stable-count debouncer and rising-edge press pulse
// for one raw mechanical button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // The count restarts whenever the synchronized input agrees with the level.
    always_comb begin
        sync_d  = {sync_q[0], btn_i};
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/letter_entry.sv
// Three-button letter selector with a ready/valid commit port.
// Define LETTER_ENTRY_AUTOREPEAT_EN to add hold-to-repeat on up/down.
module letter_entry
    import guess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LETTER_MAX      = LETTER_MAX_DEF,
    parameter int REPEAT_CYCLES   = 4096
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                btn_up,
    input  logic                btn_down,
    input  logic                btn_enter,
    output logic [LETTER_W-1:0] cur_code,
    output logic [LETTER_W-1:0] code_o,
    output logic                code_valid,
    input  logic                code_ready
);

    localparam logic [LETTER_W-1:0] MAX_C = LETTER_W'(LETTER_MAX);

    logic up_lvl, dn_lvl, en_lvl;
    logic up_press, dn_press, en_press;
    logic up_evt, dn_evt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .resetn  (resetn),
        .btn_i   (btn_up),
        .level_o (up_lvl),
        .press_o (up_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk     (clk),
        .resetn  (resetn),
        .btn_i   (btn_down),
        .level_o (dn_lvl),
        .press_o (dn_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
        .clk     (clk),
        .resetn  (resetn),
        .btn_i   (btn_enter),
        .level_o (en_lvl),
        .press_o (en_press)
    );

    state_t              state_q, state_d;
    logic [LETTER_W-1:0] cur_code_q, cur_code_d;
    logic [LETTER_W-1:0] code_o_q, code_o_d;
    logic                code_valid_q, code_valid_d;

`ifdef LETTER_ENTRY_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] up_rpt_q, up_rpt_d, dn_rpt_q, dn_rpt_d;
    logic             up_rpt_pulse_q, up_rpt_pulse_d, dn_rpt_pulse_q, dn_rpt_pulse_d;
    logic             unused_lvl;

    // Counters run only while the button is held in SELECT; anything else clears them.
    always_comb begin
        up_rpt_d       = '0;
        up_rpt_pulse_d = 1'b0;
        dn_rpt_d       = '0;
        dn_rpt_pulse_d = 1'b0;
        if (up_lvl && (state_q == SELECT)) begin
            if (up_rpt_q == RPT_LAST) begin
                up_rpt_pulse_d = 1'b1;
            end else begin
                up_rpt_d = up_rpt_q + 1'b1;
            end
        end
        if (dn_lvl && (state_q == SELECT)) begin
            if (dn_rpt_q == RPT_LAST) begin
                dn_rpt_pulse_d = 1'b1;
            end else begin
                dn_rpt_d = dn_rpt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            up_rpt_q       <= '0;
            dn_rpt_q       <= '0;
            up_rpt_pulse_q <= 1'b0;
            dn_rpt_pulse_q <= 1'b0;
        end else begin
            up_rpt_q       <= up_rpt_d;
            dn_rpt_q       <= dn_rpt_d;
            up_rpt_pulse_q <= up_rpt_pulse_d;
            dn_rpt_pulse_q <= dn_rpt_pulse_d;
        end
    end

    assign up_evt     = up_press | up_rpt_pulse_q;
    assign dn_evt     = dn_press | dn_rpt_pulse_q;
    assign unused_lvl = en_lvl;
`else
    localparam int UNUSED_REPEAT_CYCLES = REPEAT_CYCLES;
    logic unused_lvl;

    assign up_evt     = up_press;
    assign dn_evt     = dn_press;
    assign unused_lvl = ^{up_lvl, dn_lvl, en_lvl};
`endif

    // Enter wins over a same-cycle step so the committed code is the pre-step value.
    always_comb begin
        state_d      = state_q;
        cur_code_d   = cur_code_q;
        code_o_d     = code_o_q;
        code_valid_d = code_valid_q;
        case (state_q)
            SELECT: begin
                if (en_press) begin
                    code_o_d     = cur_code_q;
                    code_valid_d = 1'b1;
                    state_d      = PRESENT;
                end else if (up_evt && !dn_evt) begin
                    cur_code_d = code_inc(cur_code_q, MAX_C);
                end else if (dn_evt && !up_evt) begin
                    cur_code_d = code_dec(cur_code_q, MAX_C);
                end
            end
            PRESENT: begin
                if (code_valid_q && code_ready) begin
                    code_valid_d = 1'b0;
                    state_d      = SELECT;
                end
            end
            default: begin
                code_valid_d = 1'b0;
                state_d      = SELECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= SELECT;
            cur_code_q   <= '0;
            code_o_q     <= '0;
            code_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_code_q   <= cur_code_d;
            code_o_q     <= code_o_d;
            code_valid_q <= code_valid_d;
        end
    end

    assign cur_code   = cur_code_q;
    assign code_o     = code_o_q;
    assign code_valid = code_valid_q;

endmodule

// File: tb/tb_letter_entry.sv
// Directed bench for letter_entry (DEBOUNCE_CYCLES=4, LETTER_MAX=25, REPEAT_CYCLES=8).
module tb_letter_entry;

    logic       clk;
    logic       resetn;
    logic       btn_up, btn_down, btn_enter;
    logic [4:0] cur_code;
    logic [4:0] code_o;
    logic       code_valid;
    logic       code_ready;

    int         tests = 0;
    int         errs  = 0;
    logic [4:0] exp_code;

    letter_entry #(
        .DEBOUNCE_CYCLES (4),
        .LETTER_MAX      (25),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_enter  (btn_enter),
        .cur_code   (cur_code),
        .code_o     (code_o),
        .code_valid (code_valid),
        .code_ready (code_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] m_inc(input logic [4:0] c);
        return (c == 5'd25) ? 5'd0 : c + 5'd1;
    endfunction

    function automatic logic [4:0] m_dec(input logic [4:0] c);
        return (c == 5'd0) ? 5'd25 : c - 5'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input logic u, input logic d, input logic e);
        btn_up    = u;
        btn_down  = d;
        btn_enter = e;
    endtask

    // Raw rise, then the code must hold for 6 edges and change on the 7th.
    task automatic press(input logic u, input logic d, input logic e,
                         input logic [4:0] exp_after, input string tag);
        set_btn(u, d, e);
        step(6);
        chk({tag, "_hold"}, cur_code, exp_code);
        step(1);
        chk(tag, cur_code, exp_after);
        set_btn(0, 0, 0);
        step(10);
        exp_code = exp_after;
    endtask

    initial begin
        resetn     = 1'b1;
        code_ready = 1'b0;
        set_btn(0, 0, 0);
        exp_code   = 5'd0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_cur", cur_code, 0);
        chk("rst_code_o", code_o, 0);
        chk("rst_valid", code_valid, 0);
        step(2);
        resetn = 1'b1;
        step(2);

        for (int i = 0; i < 3; i++) press(1, 0, 0, m_inc(exp_code), "up_clean");
        chk("up3_value", cur_code, 3);
        for (int i = 0; i < 3; i++) press(0, 1, 0, m_dec(exp_code), "down_clean");
        press(0, 1, 0, 5'd25, "down_wrap");
        press(1, 0, 0, 5'd0, "up_wrap");

        for (int i = 0; i < 2; i++) begin
            set_btn(1, 0, 0);
            step(3);
            set_btn(0, 0, 0);
            step(3);
        end
        step(6);
        chk("glitch_no_inc", cur_code, 0);
        press(1, 0, 0, 5'd1, "glitch_settle");

        for (int i = 0; i < 6; i++) press(1, 0, 0, m_inc(exp_code), "up_nav7");
        press(0, 0, 1, exp_code, "enter7");
        chk("enter7_code", code_o, 7);
        chk("enter7_valid", code_valid, 1);
        press(1, 0, 0, exp_code, "present_up_ignored");
        press(0, 0, 1, exp_code, "present_enter_ignored");
        chk("present_code_hold", code_o, 7);
        chk("present_valid_hold", code_valid, 1);
        code_ready = 1'b1;
        step(1);
        chk("ready_drop_valid", code_valid, 0);
        chk("ready_keep_cur", cur_code, 7);
        code_ready = 1'b0;
        press(1, 0, 0, 5'd8, "select_after_ready");

        press(1, 1, 0, exp_code, "up_down_same");
        for (int i = 0; i < 4; i++) press(0, 1, 0, m_dec(exp_code), "down_nav4");
        press(1, 0, 1, exp_code, "enter_with_up");
        chk("enter_up_code", code_o, 4);
        chk("enter_up_valid", code_valid, 1);
        code_ready = 1'b1;
        step(1);
        code_ready = 1'b0;
        chk("ready2_drop", code_valid, 0);

        for (int i = 0; i < 8; i++) press(1, 0, 0, m_inc(exp_code), "up_nav12");
        press(0, 0, 1, exp_code, "enter12");
        chk("enter12_code", code_o, 12);

        set_btn(1, 0, 0);
        step(3);
        resetn = 1'b0;
        #1;
        chk("midrst_valid", code_valid, 0);
        chk("midrst_cur", cur_code, 0);
        chk("midrst_code_o", code_o, 0);
        step(2);
        resetn = 1'b1;
        step(6);
        chk("held_rel_hold", cur_code, 0);
        step(1);
        chk("held_rel_inc", cur_code, 1);
        step(29);
`ifdef LETTER_ENTRY_AUTOREPEAT_EN
        chk("held_repeat", cur_code, 4);
`else
        chk("held_repeat", cur_code, 1);
`endif
        set_btn(0, 0, 0);
        step(10);

        code_ready = 1'b1;
        step(3);
        code_ready = 1'b0;
        chk("ready_idle_valid", code_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule

// File: doc/letter_entry.md
LETTER_ENTRY -- requirements
Module: letter_entry

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles before a button level is accepted.
REQ-002 SHALL have parameter LETTER_MAX, default 25: highest selectable 5-bit letter code (0 = first letter).
REQ-003 SHALL have parameter REPEAT_CYCLES, default 4096: auto-repeat period (used only when the REQ-028 macro is defined).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 btn_up  input  1  raw asynchronous button, active-high, bouncy.
REQ-007 btn_down  input  1  raw asynchronous button, active-high, bouncy.
REQ-008 btn_enter  input  1  raw asynchronous button, active-high, bouncy.
REQ-009 cur_code  output  5  letter currently selected; feeds the 7-segment letter decoder continuously.
REQ-010 code_o  output  5  committed letter code, valid while code_valid=1.
REQ-011 code_valid  output  1  committed code available.
REQ-012 code_ready  input  1  consumer accepts code_o when code_valid and code_ready are both 1 on a clock edge.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer: debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-014 A press pulse (one cycle) SHALL be generated on each 0->1 transition of a debounced level; releases generate nothing.
REQ-015 FSM states SHALL be SELECT and PRESENT.
REQ-016 In SELECT, an up pulse SHALL set cur_code to cur_code+1 on the next edge, wrapping LETTER_MAX -> 0.
REQ-017 In SELECT, a down pulse SHALL set cur_code to cur_code-1 on the next edge, wrapping 0 -> LETTER_MAX.
REQ-018 Up and down pulses in the same cycle SHALL leave cur_code unchanged.
REQ-019 In SELECT, an enter pulse SHALL, on the next edge, load code_o=cur_code, assert code_valid and move to PRESENT; a same-cycle up/down pulse is ignored and the pre-update cur_code is committed.
REQ-020 In PRESENT, code_o and code_valid SHALL hold stable; up, down and enter pulses SHALL be discarded, not queued.
REQ-021 In PRESENT, code_valid&code_ready on an edge SHALL deassert code_valid on that edge and return to SELECT; cur_code is retained.
REQ-022 code_ready while code_valid=0 SHALL have no effect.
REQ-023 cur_code SHALL never exceed LETTER_MAX; arithmetic is 5-bit with explicit wrap compare, no overflow reliance.

Reset
REQ-024 resetn=0 SHALL immediately force: state SELECT, cur_code=0, code_o=0, code_valid=0, synchronizer/debounce levels 0, debounce counters 0, repeat counter 0.
REQ-025 Reset asserted mid-press or in PRESENT SHALL abandon the operation; a button still held at reset release SHALL produce one press pulse after DEBOUNCE_CYCLES+2 cycles.
REQ-026 Reset deassertion is assumed synchronized externally; block SHALL take no action in the first cycle after release other than sampling.

Configuration
REQ-027 Macro LETTER_ENTRY_AUTOREPEAT_EN SHALL gate the auto-repeat feature.
REQ-028 Defined: while up (or down) remains debounced-high in SELECT, an additional pulse SHALL be generated every REPEAT_CYCLES cycles after the initial pulse; counter clears on release or leaving SELECT.
REQ-029 Not defined: exactly one pulse per press; repeat counter and REPEAT_CYCLES logic SHALL be absent from the netlist.

Structure
REQ-030 Shared package guess_pkg SHALL hold LETTER_W=5, default LETTER_MAX, and the FSM state typedef.
REQ-031 Debounce/synchronize/edge-detect SHALL be sub-module btn_debounce, instantiated three times.

Verification (bench uses DEBOUNCE_CYCLES=4, LETTER_MAX=25, REPEAT_CYCLES=8)
REQ-032 Reset, 3 clean up presses -> cur_code 0,1,2,3; each update 7 cycles after raw rise (2 sync + 4 debounce + 1).
REQ-033 Down from cur_code=0 -> 25; up from 25 -> 0; up with 3-cycle glitches between bounces -> exactly one increment.
REQ-034 cur_code=7, enter, code_ready=0 for 10 cycles while pressing up -> code_o=7, code_valid held, cur_code stays 7; code_ready=1 -> code_valid drops same edge, state SELECT.
REQ-035 Up and down raw rises same cycle -> cur_code unchanged; enter with simultaneous up at cur_code=4 -> code_o=4.
REQ-036 resetn pulsed low in PRESENT with code_o=12 -> code_valid=0, cur_code=0 asynchronously; held up at release -> one increment to 1.
REQ-037 With LETTER_ENTRY_AUTOREPEAT_EN, up held 30 cycles past debounce -> cur_code 0 -> 4 (initial + 3 repeats); without macro -> 1.
